// File: rtl/pp_accum_if.sv
// Input and output bundle of the pp_accum batch accumulator.
// o_sum width follows PP_ACCUM_SATURATE_EN (OUT_W when defined, else full accumulator width).
interface pp_accum_if #(
    parameter int NUM_PP = 8,
    parameter int PP_W   = 15,
    parameter int OUT_W  = 16
);
    localparam int ACC_W = PP_W + $clog2(NUM_PP);
    localparam int CNT_W = $clog2(NUM_PP) + 1;
`ifdef PP_ACCUM_SATURATE_EN
    localparam int SUM_W = OUT_W;
`else
    localparam int SUM_W = ACC_W;
`endif

    // No backpressure: a product is accepted on every cycle where i_valid is high.
    // o_valid is a single-cycle pulse; the other outputs hold until the next pulse.
    logic             i_valid;
    logic [PP_W-1:0]  i_align_pp;
    logic [4:0]       i_Q_frac;
    logic             i_flush;
    logic             o_valid;
    logic [SUM_W-1:0] o_sum;
    logic [4:0]       o_Q_frac;
    logic [CNT_W-1:0] o_count;
    logic             o_qf_err;

    modport master (
        output i_valid, i_align_pp, i_Q_frac, i_flush,
        input  o_valid, o_sum, o_Q_frac, o_count, o_qf_err
    );

    modport slave (
        input  i_valid, i_align_pp, i_Q_frac, i_flush,
        output o_valid, o_sum, o_Q_frac, o_count, o_qf_err
    );
endinterface

// File: rtl/pp_accum.sv
// Batch accumulator of sign-extended aligned partial products; closes on NUM_PP accepts or flush.
// Optional output clamp to OUT_W bits when PP_ACCUM_SATURATE_EN is defined.
module pp_accum #(
    parameter int NUM_PP = 8,
    parameter int PP_W   = 15,
    parameter int OUT_W  = 16
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    pp_accum_if.slave bus,
    output logic     o_dbg_state
);
    localparam int ACC_W = PP_W + $clog2(NUM_PP);
    localparam int CNT_W = $clog2(NUM_PP) + 1;
`ifdef PP_ACCUM_SATURATE_EN
    localparam int SUM_W = OUT_W;
    localparam longint SAT_MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_L);
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_L - 1);
`else
    localparam int SUM_W = ACC_W;
`endif

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       tag_q, tag_d;
    logic             err_q, err_d;

    logic             ovalid_q, ovalid_d;
    logic [SUM_W-1:0] osum_q, osum_d;
    logic [4:0]       oqf_q, oqf_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oerr_q, oerr_d;

    logic [ACC_W-1:0] pp_ext;
    logic [ACC_W-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [4:0]       tag_nx;
    logic             err_nx;
    logic [SUM_W-1:0] sum_nx;
    logic             close;

    assign pp_ext = {{(ACC_W - PP_W){bus.i_align_pp[PP_W-1]}}, bus.i_align_pp};

    // Batch contents including this cycle's product, if any.
    always_comb begin
        acc_nx = acc_q;
        cnt_nx = cnt_q;
        tag_nx = tag_q;
        err_nx = err_q;
        if (bus.i_valid) begin
            if (state_q == IDLE) begin
                acc_nx = pp_ext;
                cnt_nx = CNT_W'(1);
                tag_nx = bus.i_Q_frac;
                err_nx = 1'b0;
            end else begin
                acc_nx = acc_q + pp_ext;
                cnt_nx = cnt_q + CNT_W'(1);
                err_nx = err_q | (bus.i_Q_frac != tag_q);
            end
        end
    end

`ifdef PP_ACCUM_SATURATE_EN
    always_comb begin
        sum_nx = acc_nx[SUM_W-1:0];
        if ($signed(acc_nx) > $signed(SAT_MAX)) begin
            sum_nx = SAT_MAX[SUM_W-1:0];
        end else if ($signed(acc_nx) < $signed(SAT_MIN)) begin
            sum_nx = SAT_MIN[SUM_W-1:0];
        end
    end
`else
    assign sum_nx = acc_nx;
`endif

    // A flush in IDLE only closes when it brings a product with it.
    assign close = (bus.i_valid && (cnt_nx == CNT_W'(NUM_PP)))
                || (bus.i_flush && (bus.i_valid || (state_q == ACC)));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        err_d    = err_q;
        ovalid_d = 1'b0;
        osum_d   = osum_q;
        oqf_d    = oqf_q;
        ocnt_d   = ocnt_q;
        oerr_d   = oerr_q;
        if (close) begin
            ovalid_d = 1'b1;
            osum_d   = sum_nx;
            oqf_d    = tag_nx;
            ocnt_d   = cnt_nx;
            oerr_d   = err_nx;
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (bus.i_valid) begin
            state_d = ACC;
            acc_d   = acc_nx;
            cnt_d   = cnt_nx;
            tag_d   = tag_nx;
            err_d   = err_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
            osum_q   <= '0;
            oqf_q    <= '0;
            ocnt_q   <= '0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
            osum_q   <= osum_d;
            oqf_q    <= oqf_d;
            ocnt_q   <= ocnt_d;
            oerr_q   <= oerr_d;
        end
    end

    assign bus.o_valid  = ovalid_q;
    assign bus.o_sum    = osum_q;
    assign bus.o_Q_frac = oqf_q;
    assign bus.o_count  = ocnt_q;
    assign bus.o_qf_err = oerr_q;
    assign o_dbg_state  = state_q;
endmodule

// File: tb/tb_pp_accum.sv
// Bench for pp_accum: directed batches plus random traffic checked against a queue-based batch model.
// Honours PP_ACCUM_SATURATE_EN when compiled with it.
module tb_pp_accum;
    localparam int NUM_PP = 8;
    localparam int PP_W   = 15;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = PP_W + $clog2(NUM_PP);
    localparam int CNT_W  = $clog2(NUM_PP) + 1;
`ifdef PP_ACCUM_SATURATE_EN
    localparam int SUM_W  = OUT_W;
`else
    localparam int SUM_W  = ACC_W;
`endif
    localparam int EXP_W  = 1 + CNT_W + 5 + SUM_W;

    logic i_clk;
    logic i_rst_n;
    logic dbg_state;

    pp_accum_if #(.NUM_PP(NUM_PP), .PP_W(PP_W), .OUT_W(OUT_W)) bus ();

    pp_accum #(.NUM_PP(NUM_PP), .PP_W(PP_W), .OUT_W(OUT_W)) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] last_out;
    int               batch[$];
    logic [4:0]       batch_tags[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the batch is a list of signed products; close rules applied to the list.
    task automatic model_edge(input logic v, input logic [PP_W-1:0] pp, input logic [4:0] q,
                              input logic f, output logic closed);
        int         s;
        logic       err;
        logic [SUM_W-1:0] sum_bits;
        closed = 1'b0;
        if (v) begin
            batch.push_back(int'($signed(pp)));
            batch_tags.push_back(q);
        end
        if ((v && batch.size() == NUM_PP) || (f && batch.size() > 0)) begin
            s   = 0;
            err = 1'b0;
            foreach (batch[i]) s += batch[i];
            foreach (batch_tags[i]) if (batch_tags[i] != batch_tags[0]) err = 1'b1;
`ifdef PP_ACCUM_SATURATE_EN
            if (s > (1 << (OUT_W - 1)) - 1) s = (1 << (OUT_W - 1)) - 1;
            if (s < -(1 << (OUT_W - 1)))    s = -(1 << (OUT_W - 1));
`endif
            sum_bits = SUM_W'(s);
            exp_q.push_back({err, CNT_W'(batch.size()), batch_tags[0], sum_bits});
            batch.delete();
            batch_tags.delete();
            closed = 1'b1;
        end
    endtask

    function automatic logic [EXP_W-1:0] observed();
        return {bus.o_qf_err, bus.o_count, bus.o_Q_frac, bus.o_sum};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [PP_W-1:0] pp, input logic [4:0] q, input logic f);
        logic             closed;
        logic [EXP_W-1:0] e;
        bus.i_valid    = v;
        bus.i_align_pp = pp;
        bus.i_Q_frac   = q;
        bus.i_flush    = f;
        @(posedge i_clk);
        model_edge(v, pp, q, f, closed);
        #1;
        check("state", 64'(dbg_state), 64'(batch.size() > 0));
        if (closed) begin
            e = exp_q.pop_front();
            check("o_valid",  64'(bus.o_valid),  64'(1));
            check("o_sum",    64'(bus.o_sum),    64'(e[SUM_W-1:0]));
            check("o_Q_frac", 64'(bus.o_Q_frac), 64'(e[SUM_W+4:SUM_W]));
            check("o_count",  64'(bus.o_count),  64'(e[SUM_W+5+CNT_W-1:SUM_W+5]));
            check("o_qf_err", 64'(bus.o_qf_err), 64'(e[EXP_W-1]));
            last_out = e;
        end else begin
            check("no_pulse", 64'(bus.o_valid), 64'(0));
            check("hold", 64'(observed()), 64'(last_out));
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid    = 1'b0;
        bus.i_align_pp = '0;
        bus.i_Q_frac   = '0;
        bus.i_flush    = 1'b0;
    endtask

    // Asynchronous assert between edges; release on the falling edge.
    task automatic apply_reset();
        idle_inputs();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_out",   64'(observed()),  64'(0));
        check("rst_state", 64'(dbg_state),   64'(0));
        batch.delete();
        batch_tags.delete();
        exp_q.delete();
        last_out = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] base_tag;
        logic [4:0] q;
        idle_inputs();
        last_out = '0;
        i_rst_n  = 1'b0;
        #12;
        check("por_valid", 64'(bus.o_valid), 64'(0));
        check("por_out",   64'(observed()),  64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 8 x +2048, tag 3
        for (int i = 0; i < 8; i++) step(1'b1, 15'h0800, 5'd3, 1'b0);
        check("t1_sum", 64'(bus.o_sum), 64'(16384));
        check("t1_cnt", 64'(bus.o_count), 64'(8));
        step(1'b0, '0, '0, 1'b0);

        // +100 x4, -100 x4 with gaps
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i < 4) ? 15'd100 : 15'h7F9C, 5'd2, 1'b0);
            step(1'b0, '0, '0, 1'b0);
        end
        check("t2_sum", 64'(bus.o_sum), 64'(0));

        // flush cases
        for (int i = 0; i < 3; i++) step(1'b1, 15'd5, 5'd1, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        check("t3_sum", 64'(bus.o_sum), 64'(15));
        check("t3_cnt", 64'(bus.o_count), 64'(3));
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, 15'd7, 5'd1, 1'b1);
        check("t3_single_sum", 64'(bus.o_sum), 64'(7));
        check("t3_single_cnt", 64'(bus.o_count), 64'(1));

        // tag mismatch then clean batch
        for (int i = 0; i < 8; i++) step(1'b1, 15'd1, (i == 2) ? 5'd4 : 5'd3, 1'b0);
        check("t4_err", 64'(bus.o_qf_err), 64'(1));
        check("t4_tag", 64'(bus.o_Q_frac), 64'(3));
        for (int i = 0; i < 8; i++) step(1'b1, 15'd1, 5'd3, 1'b0);
        check("t4_clean", 64'(bus.o_qf_err), 64'(0));

        // most negative batch
        for (int i = 0; i < 8; i++) step(1'b1, 15'h4000, 5'd0, 1'b0);
`ifdef PP_ACCUM_SATURATE_EN
        check("t5_sum", 64'(bus.o_sum), 64'h8000);
`else
        check("t5_sum", 64'(bus.o_sum), 64'h20000);
`endif

        // reset mid-batch
        for (int i = 0; i < 5; i++) step(1'b1, 15'd9, 5'd6, 1'b0);
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 15'd1, 5'd0, 1'b0);
        check("t6_sum", 64'(bus.o_sum), 64'(8));
        check("t6_cnt", 64'(bus.o_count), 64'(8));
        step(1'b0, '0, '0, 1'b0);

        // random traffic
        base_tag = 5'($urandom_range(0, 31));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) base_tag = 5'($urandom_range(0, 31));
            q = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : base_tag;
            if ($urandom_range(0, 700) == 0) apply_reset();
            step($urandom_range(0, 9) < 7, PP_W'($urandom), q, $urandom_range(0, 11) == 0);
        end
        idle_inputs();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pp_accum.md
# pp_accum

Sequential accumulator directly downstream of the exponent-alignment stage in the MAC subsystem. It consumes one aligned, sign-extended partial product per valid cycle and sums a batch of `NUM_PP` products into a widened two's-complement result. It emits the batch sum with a one-cycle valid pulse, the batch's `Q_frac` tag and an accepted-product count. The downstream normalise/round stage consumes this output.

## Interface
- `NUM_PP`, default 8: partial products per batch; must be ≥2.
- `PP_W`, default 15: width of incoming aligned partial product (signed).
- `OUT_W`, default 16: saturated output width; used only when saturation is compiled in.
- `ACC_W`, derived = `PP_W + $clog2(NUM_PP)` (18 at defaults): accumulator and unsaturated output width.
- `i_clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_valid`  in  1: `i_align_pp` / `i_Q_frac` valid this cycle.
- `i_align_pp`  in  `PP_W`: aligned partial product, two's complement.
- `i_Q_frac`  in  5: fraction-position tag carried with the product.
- `i_flush`  in  1: close the current batch early.
- `o_valid`  out  1: single-cycle pulse; batch result valid.
- `o_sum`  out  `ACC_W` (`OUT_W` with saturation): batch sum, two's complement.
- `o_Q_frac`  out  5: tag of the first product of the batch.
- `o_count`  out  `$clog2(NUM_PP)+1`: number of products summed.
- `o_qf_err`  out  1: some product in the batch carried a `Q_frac` different from the first.

## Operation
- States:
  - IDLE: no product accepted in the current batch; count = 0.
  - ACC: one or more products accepted.
- Accept on every cycle with `i_valid=1`; there is no backpressure. Gaps (`i_valid=0`) hold the accumulator, count and state unchanged.
- `i_align_pp` is sign-extended to `ACC_W` before addition. No overflow is possible in `ACC_W` for `NUM_PP` products.
- IDLE + valid:
  - acc ← sext(pp), count ← 1, tag ← `i_Q_frac`, err ← 0.
  - Move to ACC.
- ACC + valid:
  - acc ← acc + sext(pp), count ← count + 1.
  - err ← err | (`i_Q_frac` ≠ tag).
- Batch closes when:
  - the accepted product makes count = `NUM_PP`, or
  - `i_flush=1` while in ACC, or
  - `i_flush=1` together with `i_valid=1` in IDLE. That product is included, giving a batch of 1.
- On close, next edge:
  - Output registers load acc (including the closing product), count, tag and err; `o_valid` ← 1.
  - State returns to IDLE.
- Back-to-back: a product arriving the cycle after close starts a new batch normally. There are no dead cycles.
- `i_flush` in IDLE without `i_valid`: ignored, no output pulse.
- `i_flush` together with `i_valid` in ACC: the product is included, then the batch closes.
- Output registers hold their values until the next close. Only `o_valid` returns to 0 after one cycle.

## Timing
- Latency: `o_valid` asserts exactly 1 cycle after the closing accept or flush edge.
- Throughput: 1 product per cycle, sustained.
- Reset (async assert, sync-safe deassert):
  - state = IDLE, acc = 0, count = 0.
  - `o_valid`=0, `o_sum`=0, `o_Q_frac`=0, `o_count`=0, `o_qf_err`=0.
- Reset mid-batch discards the partial batch; no output is produced for it.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PP_ACCUM_SATURATE_EN` defined:
  - `o_sum` is `OUT_W` bits.
  - The closed accumulator value is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1] before registering.
  - Internal accumulation remains full `ACC_W`.
- Not defined: `o_sum` is the full `ACC_W` accumulator and `OUT_W` is unused.

## Test plan
- Reset, then 8 back-to-back products of 0x0800 (+2048), `Q_frac`=3 → one `o_valid` pulse 1 cycle after the 8th, with `o_sum`=16384, `o_count`=8, `o_Q_frac`=3, `o_qf_err`=0.
- 4× +100 then 4× 0x7F9C (−100), valid every other cycle → single pulse after the 8th accept; `o_sum`=0; outputs hold between pulses.
- 3 products of 5, then `i_flush` alone → `o_sum`=15, `o_count`=3. A following `i_flush` in IDLE produces no pulse. `i_flush`+valid(7) in IDLE → `o_sum`=7, `o_count`=1.
- Batch with `Q_frac` 3,3,4,3,… → `o_qf_err`=1, `o_Q_frac`=3. The next clean batch → `o_qf_err`=0.
- 8× 0x4000 (−16384) → without the macro, `o_sum`=0x20000 (−131072, 18 bits). With `PP_ACCUM_SATURATE_EN` and `OUT_W`=16 → `o_sum`=0x8000.
- Assert `i_rst_n`=0 after 5 products, release, then send 8× +1 → only one pulse, with `o_sum`=8 and `o_count`=8.
